// File: rtl/dst_pkg.sv
// Shared constants and types for the 4-point DST-VII datapath.
package dst_pkg;

   localparam int unsigned IN_W_DEF    = 12;
   localparam int unsigned COEFF_W_DEF = 8;

   typedef logic [1:0] dst_row_t;

   // Row k holds the coefficients that produce output y[k].
   localparam int DST4_C [4][4] = '{
      '{29,  55,  74,  84},
      '{74,  74,   0, -74},
      '{84, -29, -74,  55},
      '{55, -84,  74, -29}
   };

endpackage

// File: rtl/dst4_pingpong_buf.sv
// Two 4-sample banks with full flags, serial write pointer and block read pointer.
module dst4_pingpong_buf
   import dst_pkg::*;
#(
   parameter int unsigned IN_W = IN_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic signed [IN_W-1:0] wr_data,
   input  logic                   rd_release,
   output logic                   wr_ok,
   output logic                   rd_full,
   output logic                   nxt_full,
   output logic signed [IN_W-1:0] rd_data [4],
   output logic signed [IN_W-1:0] alt_data [4]
);

   logic signed [IN_W-1:0] bank_q [2][4];
   logic [1:0]             full_q;
   logic [1:0]             wr_slot_q;
   logic                   wr_bank_q;
   logic                   rd_bank_q;
   logic                   alt_bank;
   logic                   wr_last;

   assign alt_bank = ~rd_bank_q;
   assign wr_last  = wr_en && (wr_slot_q == 2'd3);
   assign wr_ok    = ~full_q[wr_bank_q];
   assign rd_full  = full_q[rd_bank_q];
   // Includes a block completing this cycle so the next block can follow row 3 without a gap.
   assign nxt_full = full_q[alt_bank] || (wr_last && (wr_bank_q == alt_bank));

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         rd_data[j]  = bank_q[rd_bank_q][j];
         alt_data[j] = bank_q[alt_bank][j];
         if (wr_en && (wr_bank_q == alt_bank) && (wr_slot_q == 2'(j))) begin
            alt_data[j] = wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_q    <= '{default: '0};
         full_q    <= '0;
         wr_slot_q <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
      end else begin
         if (wr_en) begin
            bank_q[wr_bank_q][wr_slot_q] <= wr_data;
            wr_slot_q                    <= wr_slot_q + 2'd1;
            if (wr_last) begin
               full_q[wr_bank_q] <= 1'b1;
               wr_bank_q         <= ~wr_bank_q;
            end
         end
         if (rd_release) begin
            full_q[rd_bank_q] <= 1'b0;
            rd_bank_q         <= ~rd_bank_q;
         end
      end
   end

endmodule

// File: rtl/dst4_row_sequencer.sv
// Feeds the 4-tap MAC: buffers sample blocks and issues one beat per DST4 coefficient row.
module dst4_row_sequencer
   import dst_pkg::*;
#(
   parameter int unsigned IN_W    = IN_W_DEF,
   parameter int unsigned COEFF_W = COEFF_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic signed [IN_W-1:0]    s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic signed [IN_W-1:0]    m_x [4],
   output logic signed [COEFF_W-1:0] m_c [4],
   output dst_row_t                  m_row,
   output logic                      m_last
);

   typedef enum logic [0:0] {StIdle, StIssue} state_t;

   state_t                 state_q, state_d;
   dst_row_t               row_q, row_d;
   logic                   wr_ok, rd_full, nxt_full;
   logic                   wr_en, hs, rd_release, load, load_alt, advance;
   logic signed [IN_W-1:0] rd_data [4];
   logic signed [IN_W-1:0] alt_data [4];

   assign s_ready = rst_n & wr_ok;
   assign wr_en   = s_valid & s_ready;
   assign m_valid = (state_q == StIssue);
   assign m_row   = row_q;
   assign hs      = m_valid & m_ready;

   dst4_pingpong_buf #(
      .IN_W (IN_W)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_en),
      .wr_data    (s_data),
      .rd_release (rd_release),
      .wr_ok      (wr_ok),
      .rd_full    (rd_full),
      .nxt_full   (nxt_full),
      .rd_data    (rd_data),
      .alt_data   (alt_data)
   );

   always_comb begin
      state_d    = state_q;
      row_d      = row_q;
      rd_release = 1'b0;
      load       = 1'b0;
      load_alt   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rd_full) begin
               state_d = StIssue;
               row_d   = 2'd0;
               load    = 1'b1;
            end
         end
         StIssue: begin
            if (hs) begin
               if (row_q == 2'd3) begin
                  rd_release = 1'b1;
                  row_d      = 2'd0;
                  if (nxt_full) begin
                     load     = 1'b1;
                     load_alt = 1'b1;
                  end else begin
                     state_d = StIdle;
                  end
               end else begin
                  row_d = row_q + 2'd1;
               end
            end
         end
      endcase
      advance = (state_d == StIssue) && (load || hs);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         row_q   <= '0;
         m_last  <= 1'b0;
         m_x     <= '{default: '0};
         m_c     <= '{default: '0};
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         if (advance) begin
            m_last <= (row_d == 2'd3);
            for (int j = 0; j < 4; j++) begin
               m_c[j] <= COEFF_W'(DST4_C[row_d][j]);
            end
         end else if (state_d == StIdle) begin
            m_last <= 1'b0;
         end
         if (load) begin
            for (int j = 0; j < 4; j++) begin
               m_x[j] <= load_alt ? alt_data[j] : rd_data[j];
            end
         end
      end
   end

endmodule

// File: tb/tb_dst4_row_sequencer.sv
// Bench for dst4_row_sequencer: block-level model plus directed literal checks.
module tb_dst4_row_sequencer;

   localparam int IN_W    = 12;
   localparam int COEFF_W = 8;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      s_valid = 1'b0;
   logic                      s_ready;
   logic signed [IN_W-1:0]    s_data = '0;
   logic                      m_valid;
   logic                      m_ready = 1'b0;
   logic signed [IN_W-1:0]    m_x [4];
   logic signed [COEFF_W-1:0] m_c [4];
   logic [1:0]                m_row;
   logic                      m_last;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int stall_cnt = 0;
   int acc_q[$];
   int exp_x_q[$];
   int exp_row_q[$];
   int hs_cyc_q[$];
   int coef_tb [4][4] = '{
      '{29,  55,  74,  84},
      '{74,  74,   0, -74},
      '{84, -29, -74,  55},
      '{55, -84,  74, -29}
   };
   bit beat_ok;
   int er;

   dst4_row_sequencer #(
      .IN_W    (IN_W),
      .COEFF_W (COEFF_W)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_x     (m_x),
      .m_c     (m_c),
      .m_row   (m_row),
      .m_last  (m_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input string got, input string want);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %s, want %s", name, got, want);
      end
   endtask

   function automatic bit x_is(input int a, input int b, input int c, input int d);
      return int'(m_x[0]) == a && int'(m_x[1]) == b && int'(m_x[2]) == c && int'(m_x[3]) == d;
   endfunction

   function automatic bit c_is(input int a, input int b, input int c, input int d);
      return int'(m_c[0]) == a && int'(m_c[1]) == b && int'(m_c[2]) == c && int'(m_c[3]) == d;
   endfunction

   function automatic string outs();
      return $sformatf("v%0b row%0d last%0b x %0d %0d %0d %0d c %0d %0d %0d %0d", m_valid, m_row,
                       m_last, m_x[0], m_x[1], m_x[2], m_x[3], m_c[0], m_c[1], m_c[2], m_c[3]);
   endfunction

   // Model: every 4 accepted samples form a block that owes rows 0..3 in order.
   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid) begin
            if (exp_row_q.size() == 0) begin
               check("unexpected_beat", 1'b0, outs(), "no beat pending");
            end else begin
               er = exp_row_q[0];
               beat_ok = (int'(m_row) == er) && (m_last == (er == 3));
               for (int j = 0; j < 4; j++) begin
                  beat_ok &= (int'(m_x[j]) == exp_x_q[j]) && (int'(m_c[j]) == coef_tb[er][j]);
               end
               check("beat", beat_ok, outs(),
                     $sformatf("row%0d last%0b x %0d %0d %0d %0d c %0d %0d %0d %0d", er, er == 3,
                               exp_x_q[0], exp_x_q[1], exp_x_q[2], exp_x_q[3], coef_tb[er][0],
                               coef_tb[er][1], coef_tb[er][2], coef_tb[er][3]));
               if (m_ready) begin
                  hs_cyc_q.push_back(cyc);
                  void'(exp_row_q.pop_front());
                  for (int j = 0; j < 4; j++) void'(exp_x_q.pop_front());
               end
            end
         end
         if (s_valid && s_ready) begin
            acc_q.push_back(int'(s_data));
            if (acc_q.size() == 4) begin
               for (int r = 0; r < 4; r++) begin
                  exp_row_q.push_back(r);
                  for (int j = 0; j < 4; j++) exp_x_q.push_back(acc_q[j]);
               end
               acc_q.delete();
            end
         end
      end
   end

   task automatic do_reset();
      s_valid = 1'b0;
      rst_n   = 1'b0;
      #1;
      check("rst_m_valid", m_valid == 1'b0, $sformatf("%0b", m_valid), "0");
      check("rst_m_row", m_row == 2'd0, $sformatf("%0d", m_row), "0");
      check("rst_m_last", m_last == 1'b0, $sformatf("%0b", m_last), "0");
      check("rst_s_ready", s_ready == 1'b0, $sformatf("%0b", s_ready), "0");
      check("rst_x_c_zero", x_is(0, 0, 0, 0) && c_is(0, 0, 0, 0), outs(), "x and c all 0");
      acc_q.delete();
      exp_row_q.delete();
      exp_x_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d);
      int n = 0;
      s_valid = 1'b1;
      s_data  = IN_W'(d);
      @(negedge clk);
      while (!s_ready && n < 50) begin
         stall_cnt++;
         n++;
         @(negedge clk);
      end
      if (!s_ready) check("send_timeout", 1'b0, "s_ready 0 for 50 cycles", "accept");
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_row_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_row_q.size() == 0, $sformatf("%0d beats left", exp_row_q.size()), "0");
      repeat (2) @(negedge clk);
      check("idle_after_drain", m_valid == 1'b0, $sformatf("%0b", m_valid), "0");
      @(posedge clk);
      #1;
   endtask

   task automatic wait_row(input int r, input string name);
      int n = 0;
      @(negedge clk);
      while (!(m_valid && int'(m_row) == r) && n < 30) begin
         @(negedge clk);
         n++;
      end
      check(name, m_valid && int'(m_row) == r, outs(), $sformatf("valid row%0d", r));
   endtask

   initial begin
      do_reset();

      // Single block, m_ready high: row 0 one edge after the 4th sample.
      m_ready = 1'b1;
      send(10); send(-20); send(30); send(-40);
      s_valid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t1_beat", m_valid && int'(m_row) == i && m_last == (i == 3) &&
               x_is(10, -20, 30, -40), outs(), $sformatf("valid row%0d x 10 -20 30 -40", i));
         if (i == 1) check("t1_row1_coef", c_is(74, 74, 0, -74), outs(), "c 74 74 0 -74");
      end
      drain();

      // Three blocks streamed; bank 0 frees only on block 0's row-3 edge, costing one stall.
      hs_cyc_q.delete();
      stall_cnt = 0;
      for (int i = 0; i < 12; i++) send(i * 37 - 200);
      s_valid = 1'b0;
      drain();
      check("t2_beats", hs_cyc_q.size() == 12, $sformatf("%0d", hs_cyc_q.size()), "12");
      for (int i = 1; i < hs_cyc_q.size(); i++) begin
         check("t2_no_gap", hs_cyc_q[i] - hs_cyc_q[i-1] == 1,
               $sformatf("gap %0d at beat %0d", hs_cyc_q[i] - hs_cyc_q[i-1], i), "1");
      end
      check("t2_stalls", stall_cnt == 1, $sformatf("%0d", stall_cnt), "1");

      // Back-pressure: both banks fill, input stalls, row 0 held.
      m_ready = 1'b0;
      for (int i = 1; i <= 8; i++) send(i);
      s_valid = 1'b1;
      s_data  = IN_W'(9);
      repeat (5) begin
         @(negedge clk);
         check("t3_hold", !s_ready && m_valid && m_row == 2'd0 && x_is(1, 2, 3, 4),
               $sformatf("s_ready%0b %s", s_ready, outs()), "s_ready0 valid row0 x 1 2 3 4");
      end
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      for (int i = 9; i <= 12; i++) send(i);
      s_valid = 1'b0;
      drain();

      // Rows advance only on handshakes while m_ready toggles.
      m_ready = 1'b0;
      send(-7); send(300); send(-1); send(1000);
      s_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         m_ready = (i % 2 == 1);
      end
      m_ready = 1'b1;
      drain();

      // Reset after a partial block, then mid-issue at row 2.
      send(500); send(-500);
      do_reset();
      send(-1); send(-2); send(-3); send(-4);
      s_valid = 1'b0;
      wait_row(2, "t5_reach_row2");
      #2;
      do_reset();
      send(7); send(8); send(9); send(10);
      s_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t5_fresh_row0", m_valid && m_row == 2'd0 && x_is(7, 8, 9, 10), outs(),
            "valid row0 x 7 8 9 10");
      drain();

      // Extreme samples and negative coefficients.
      m_ready = 1'b0;
      send(2047); send(-2048); send(2047); send(-2048);
      s_valid = 1'b0;
      wait_row(0, "t6_row0_valid");
      check("t6_row0", x_is(2047, -2048, 2047, -2048) && c_is(29, 55, 74, 84), outs(),
            "x 2047 -2048 2047 -2048 c 29 55 74 84");
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_row(3, "t6_row3_valid");
      check("t6_row3", x_is(2047, -2048, 2047, -2048) && c_is(55, -84, 74, -29) && m_last,
            outs(), "x 2047 -2048 2047 -2048 c 55 -84 74 -29 last1");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
